// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, frame geometry and counter sizing.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_HIGH = 3'd4
   } uart_state_e;

   localparam int unsigned UART_DATA_BITS = 8;

   // Bits needed for a counter that runs 0 .. cpb-1.
   function automatic int unsigned cnt_width(input int unsigned cpb);
      return $clog2(cpb);
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an idle-high serial line; both flops reset to 1
// so a reset never looks like a start bit.
module uart_rx_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic sync_out
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   // Next values: shift the raw line through two stages.
   always_comb begin
      meta_d = async_in;
      sync_d = meta_q;
   end

   // Synchronizer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign sync_out = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, keeps the last two bytes and strobes
// rx_done for one cycle per accepted frame.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned clk_per_bit = 21
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        serial_in,
   output logic [15:0] serial_out,
   output logic        rx_done
);

   localparam int unsigned CW = cnt_width(clk_per_bit);
   localparam int unsigned H  = (clk_per_bit - 1) / 2;
   // START is entered one cycle after t0 with the counter at 0, so matching
   // H-1 puts the start-bit check on cycle t0+H.
   localparam logic [CW-1:0] START_END = CW'(H - 1);
   localparam logic [CW-1:0] BIT_END   = CW'(clk_per_bit - 1);
   localparam logic [2:0]    LAST_BIT  = 3'(UART_DATA_BITS - 1);

   logic rx_s;

   uart_rx_sync u_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .async_in (serial_in),
      .sync_out (rx_s)
   );

   uart_state_e    state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [2:0]     idx_q, idx_d;
   logic [7:0]     shift_q, shift_d;
   logic [15:0]    data_q, data_d;
   logic           done_q, done_d;

   // Frame FSM: next state, bit counter, shift register and output update.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      data_d  = data_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (!rx_s) state_d = START;
         end
         START: begin
            if (cnt_q == START_END) begin
               cnt_d = '0;
               if (!rx_s) begin
                  state_d = DATA;
                  idx_d   = '0;
               end else begin
                  state_d = IDLE;   // line went back high: glitch, not a start
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DATA: begin
            if (cnt_q == BIT_END) begin
               cnt_d          = '0;
               shift_d[idx_q] = rx_s;
               idx_d          = idx_q + 3'd1;
               if (idx_q == LAST_BIT) state_d = STOP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         STOP: begin
            if (cnt_q == BIT_END) begin
               cnt_d = '0;
               if (rx_s) begin
                  data_d  = {data_q[7:0], shift_q};
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  state_d = WAIT_HIGH;   // framing error: drop the byte
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         WAIT_HIGH: begin
            cnt_d = '0;
            if (rx_s) state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         done_q  <= done_d;
      end
   end

   assign serial_out = data_q;
   assign rx_done    = done_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: three instances (clk_per_bit 21, 3, 16), scoreboard of
// expected pulse cycle and output word per instance.
module tb_uart_rx;
   import uart_pkg::*;

   typedef struct {
      int          cyc;
      logic [15:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [2:0]  ser = 3'b111;
   logic [15:0] so [3];
   logic [2:0]  rxd;

   int          cyc = 0;
   int          checks = 0;
   int          fails = 0;
   exp_t        q [3][$];
   logic [15:0] model [3];
   exp_t        mon_e;

   uart_rx #(.clk_per_bit(21)) dut21 (
      .clk(clk), .rst_n(rst_n), .serial_in(ser[0]), .serial_out(so[0]), .rx_done(rxd[0]));
   uart_rx #(.clk_per_bit(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .serial_in(ser[1]), .serial_out(so[1]), .rx_done(rxd[1]));
   uart_rx #(.clk_per_bit(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .serial_in(ser[2]), .serial_out(so[2]), .rx_done(rxd[2]));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int cpb_of(input int d);
      case (d)
         0:       return 21;
         1:       return 3;
         default: return 16;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive one frame on line d starting at the next falling clock edge.
   task automatic send_frame(input int d, input logic [7:0] b, input logic stop_v, input bit push);
      int c, p, h;
      @(negedge clk);
      c = cyc;
      p = cpb_of(d);
      h = (p - 1) / 2;
      if (push) begin
         model[d] = {model[d][7:0], b};
         q[d].push_back('{cyc: c + 3 + h + 9 * p, data: model[d]});
      end
      ser[d] = 1'b0;
      repeat (p - 1) @(negedge clk);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         ser[d] = b[k];
         repeat (p - 1) @(negedge clk);
      end
      @(negedge clk);
      ser[d] = stop_v;
      repeat (p - 1) @(negedge clk);
   endtask

   task automatic wait_drain(input int d);
      int n = 0;
      while (q[d].size() != 0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      assert (q[d].size() == 0) else begin
         fails++;
         $error("FAIL drain_timeout_dut%0d observed_pending=%0d required=0", d, q[d].size());
      end
   endtask

   // Pulse monitor: every rx_done must match the head of that instance's queue.
   always @(negedge clk) begin
      if (rst_n) begin
         for (int d = 0; d < 3; d++) begin
            if (rxd[d] === 1'b1) begin
               checks++;
               assert (q[d].size() != 0) else begin
                  fails++;
                  $error("FAIL unexpected_pulse_dut%0d observed=pulse@%0d required=none", d, cyc);
               end
               if (q[d].size() != 0) begin
                  mon_e = q[d].pop_front();
                  chk($sformatf("pulse_cycle_dut%0d", d), cyc, mon_e.cyc);
                  chk($sformatf("pulse_data_dut%0d", d), {16'h0, so[d]}, {16'h0, mon_e.data});
               end
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      for (int d = 0; d < 3; d++) model[d] = 16'h0;

      // Reset values
      repeat (3) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("reset_out_dut%0d", d), {16'h0, so[d]}, 32'h0);
         chk($sformatf("reset_done_dut%0d", d), {31'h0, rxd[d]}, 32'h0);
      end
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // Two back-to-back valid frames
      send_frame(0, 8'h35, 1'b1, 1'b1);
      send_frame(0, 8'hA5, 1'b1, 1'b1);
      wait_drain(0);
      chk("b2b_out", {16'h0, so[0]}, 32'h35A5);

      // Framing error, then line held low: must park in WAIT_HIGH
      send_frame(0, 8'h35, 1'b0, 1'b0);
      repeat (42) @(negedge clk);
      chk("frame_err_state", 32'(dut21.state_q), 32'(WAIT_HIGH));
      chk("frame_err_out", {16'h0, so[0]}, 32'h35A5);
      ser[0] = 1'b1;
      repeat (4) @(negedge clk);
      chk("wait_high_release", 32'(dut21.state_q), 32'(IDLE));
      repeat (5) @(negedge clk);
      send_frame(0, 8'h5A, 1'b1, 1'b1);
      wait_drain(0);
      chk("after_err_low", {24'h0, so[0][7:0]}, 32'h5A);
      chk("after_err_out", {16'h0, so[0]}, 32'hA55A);

      // 5-clock glitch: START until t0+10, IDLE right after
      repeat (5) @(negedge clk);
      c = cyc;
      ser[0] = 1'b0;
      repeat (5) @(negedge clk);
      ser[0] = 1'b1;
      repeat (7) @(negedge clk);
      chk("glitch_cycle_align", cyc, c + 12);
      chk("glitch_still_start", 32'(dut21.state_q), 32'(START));
      @(negedge clk);
      chk("glitch_back_idle", 32'(dut21.state_q), 32'(IDLE));
      repeat (20) @(negedge clk);
      chk("glitch_out", {16'h0, so[0]}, 32'hA55A);

      // Reset in the middle of data bit 4
      ser[0] = 1'b0;
      repeat (21) @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         ser[0] = k[0];
         repeat (21) @(negedge clk);
      end
      ser[0] = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_out", {16'h0, so[0]}, 32'h0);
      chk("midrst_done", {31'h0, rxd[0]}, 32'h0);
      for (int d = 0; d < 3; d++) model[d] = 16'h0;
      repeat (3) @(negedge clk);
      chk("midrst_hold_out", {16'h0, so[0]}, 32'h0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      send_frame(0, 8'h81, 1'b1, 1'b1);
      wait_drain(0);
      chk("post_rst_out", {16'h0, so[0]}, 32'h0081);

      // Parameter sweep: clk_per_bit 3 and 16
      for (int d = 1; d < 3; d++) begin
         send_frame(d, 8'hFF, 1'b1, 1'b1);
         send_frame(d, 8'h00, 1'b1, 1'b1);
         send_frame(d, 8'hFF, 1'b1, 1'b1);
         wait_drain(d);
         chk($sformatf("sweep_out_dut%0d", d), {16'h0, so[d]}, 32'h00FF);
      end

      repeat (50) @(negedge clk);
      for (int d = 0; d < 3; d++)
         chk($sformatf("final_queue_dut%0d", d), q[d].size(), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver: 8N1 frames arrive LSB-first on a single line and are assembled into a 16-bit output holding the last two received bytes. A one-cycle `rx_done` strobe marks each accepted byte. The block sits at the host-link front end and feeds received bytes to the downstream command/data logic.

## Interface
- `clk_per_bit`, default 21: system clocks per serial bit; legal range 3–255.
- `clk`  input  1  system clock; all logic on rising edge.
- `rst_n`  input  1  reset; asynchronous and active-low.
- `serial_in`  input  1  UART line; idle high, start bit low.
- `serial_out`  output  16  `{previous byte, newest byte}`; updated only on an accepted frame.
- `rx_done`  output  1  one-cycle pulse when a frame is accepted.

## Operation
- `serial_in` passes through a 2-flop synchronizer, reset to 1. All logic uses the synchronized value `rx_s`.
- `H = (clk_per_bit-1)/2` (integer division) is the mid-bit offset; `H = 10` for the default.
- **IDLE:** counter cleared. `rx_s == 0` moves to START, counter = 0.
- **START:** count to `H`. If `rx_s == 0` at `H`, go to DATA with bit index 0 and counter 0. Otherwise it is a false start; return to IDLE.
- **DATA:** sample `rx_s` each time the counter reaches `clk_per_bit-1`, then reset the counter.
  - Sample k goes to shift bit k (LSB-first).
  - After sample 7, go to STOP.
- **STOP:** sample at count `clk_per_bit-1`.
  - If 1: `serial_out <= {serial_out[7:0], byte}`, pulse `rx_done`, go to IDLE.
  - If 0 (framing error): discard the byte, leave `serial_out` unchanged, no pulse, go to WAIT_HIGH.
- **WAIT_HIGH:** stay until `rx_s == 1`, then go to IDLE. This prevents a stuck-low line from re-triggering.
- A line change during a bit is ignored; only the mid-bit sample counts.

## Timing
- Reset values: `serial_out = 16'h0000`, `rx_done = 0`, state IDLE, counter 0, synchronizer flops 1.
- `t0` is the first cycle with `rx_s == 0`, which is two clocks after the `serial_in` fall.
- Samples:
  - Start is sampled at `t0+H`.
  - Data bit k is sampled at `t0+H+(k+1)*clk_per_bit`.
  - Stop is sampled at `t0+H+9*clk_per_bit`.
- `serial_out` and `rx_done` are registered: both become visible one clock after the stop sample. `rx_done` is high for exactly one cycle.
- A new start bit can be detected in the cycle after the return to IDLE. Back-to-back frames with a full-length stop bit must be received without loss.
- Reset asserted mid-frame aborts the frame immediately and applies the reset values. The next falling edge after release begins a fresh frame.

## Structure
- Shared package `uart_pkg`:
  - state enum (IDLE, START, DATA, STOP, WAIT_HIGH);
  - `UART_DATA_BITS = 8`;
  - counter-width function `$clog2(clk_per_bit)`.
- Sub-module `uart_rx_sync`: 2-flop synchronizer with reset-to-1, reusable by the TX loopback path.
- Everything else lives in one FSM module.

## Test plan
- **Valid frame, default `clk_per_bit = 21`.** Stimulus: start 0, bits 1,0,1,0,1,1,0,0, stop 1. Response: `serial_out = 16'h0035`, one `rx_done` pulse at the stop sample + 1.
- **Second frame, back-to-back.** Stimulus: frame with byte 0xA5 immediately after the first. Response: `serial_out = 16'h35A5`, two total pulses spaced exactly 10×21 clocks apart.
- **Framing error.** Stimulus: data 0x35, line held low through the stop bit. Response: no `rx_done`, `serial_out` unchanged. FSM stays in WAIT_HIGH until the line rises, then a following valid 0x5A frame yields low byte 0x5A.
- **Glitch rejection.** Stimulus: low pulse of 5 clocks on an idle line. Response: return to IDLE at `t0+10`, no pulse, `serial_out` unchanged.
- **Reset mid-frame.** Stimulus: assert `rst_n = 0` during data bit 4 of a frame, release, then send 0x81. Response: outputs zero during reset, then `serial_out[7:0] = 8'h81` with exactly one pulse.
- **Parameter sweep.** Stimulus: `clk_per_bit = 3` and `clk_per_bit = 16` with byte 0xFF and byte 0x00. Response: correct bytes, and pulse timing per the Timing formulas.
